// File: rtl/branch_ctrl.sv
// branch_ctrl: decodes B / CBZ / B.cond, resolves taken-ness with one-cycle latency and squashes the instruction after a taken branch
module branch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        stall,
    input  logic [31:0] instr,
    input  logic [63:0] rt_data,
    input  logic        flag_we,
    input  logic [3:0]  flag_in,
    output logic        out_valid,
    output logic        UncondBr,
    output logic        BrTaken,
    output logic [63:0] CondAddr19,
    output logic [63:0] BrAddr26,
    output logic [3:0]  flags
);
    typedef enum logic {NORMAL, SQUASH} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_out_valid;
    logic        r_uncond;
    logic        r_taken;
    logic [63:0] r_cond_addr;
    logic [63:0] r_br_addr;
    logic [3:0]  r_flags;

    logic        w_accept;
    logic        w_drop;
    logic        w_fire;
    logic        w_is_b;
    logic        w_is_cbz;
    logic        w_is_bcond;
    logic [3:0]  w_flags_eff;
    logic        w_n;
    logic        w_z;
    logic        w_v;
    logic        w_cond_ok;
    logic        w_taken;

    assign in_ready    = !stall;
    assign w_accept    = in_valid && !stall;
    assign w_drop      = w_accept && (r_state == SQUASH);
    assign w_fire      = w_accept && !w_drop;

    assign w_is_b      = instr[31:26] == 6'b000101;
    assign w_is_cbz    = instr[31:24] == 8'b10110100;
    assign w_is_bcond  = instr[31:24] == 8'b01010100;

    // a flag write in the same cycle as a B.cond is forwarded to the condition
    assign w_flags_eff = flag_we ? flag_in : r_flags;
    assign w_n         = w_flags_eff[3];
    assign w_z         = w_flags_eff[2];
    assign w_v         = w_flags_eff[0];

    // evaluate the B.cond condition code against the effective flags
    always_comb begin
        w_cond_ok = 1'b0;
        case (instr[3:0])
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = !w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = !w_z && (w_n == w_v);
            4'b1101: w_cond_ok = w_z || (w_n != w_v);
            default: w_cond_ok = 1'b0;
        endcase
    end

    assign w_taken = w_is_b || (w_is_cbz && (rt_data == 64'd0)) || (w_is_bcond && w_cond_ok);

    // next state: enter SQUASH on a taken branch, leave it on the next accepted (dropped) instruction
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = (r_state == SQUASH) ? NORMAL : (w_taken ? SQUASH : NORMAL);
    end

    // state register; stall freezes it because w_accept is low while stalled
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= NORMAL;
        else
            r_state <= w_state_nxt;
    end

    // output registers: valid/taken pulse per issued instruction, fields hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_uncond    <= 1'b0;
            r_taken     <= 1'b0;
            r_cond_addr <= 64'd0;
            r_br_addr   <= 64'd0;
        end else if (!stall) begin
            r_out_valid <= w_fire;
            r_taken     <= w_fire && w_taken;
            if (w_fire) begin
                r_uncond    <= w_is_b;
                r_cond_addr <= {{45{instr[23]}}, instr[23:5]};
                r_br_addr   <= {{38{instr[25]}}, instr[25:0]};
            end
        end
    end

    // flag register loads on every write, independent of stall
    always_ff @(posedge clk) begin
        if (reset)
            r_flags <= 4'd0;
        else if (flag_we)
            r_flags <= flag_in;
    end

    assign out_valid  = r_out_valid;
    assign UncondBr   = r_uncond;
    assign BrTaken    = r_taken;
    assign CondAddr19 = r_cond_addr;
    assign BrAddr26   = r_br_addr;
    assign flags      = r_flags;
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: scoreboard bench for branch_ctrl with a behavioural reference model
module tb_branch_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic [31:0] instr;
    logic [63:0] rt_data;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic        out_valid;
    logic        UncondBr;
    logic        BrTaken;
    logic [63:0] CondAddr19;
    logic [63:0] BrAddr26;
    logic [3:0]  flags;

    typedef struct {
        logic        valid;
        logic        unc;
        logic        taken;
        logic [63:0] c19;
        logic [63:0] b26;
        logic [3:0]  flags;
        logic        chk_fields;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state: what the outputs should be, plus a pending-squash bit
    logic        m_valid, m_unc, m_taken, m_squash;
    logic [63:0] m_c19, m_b26;
    logic [3:0]  m_flags;

    branch_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .instr(instr), .rt_data(rt_data), .flag_we(flag_we),
        .flag_in(flag_in), .out_valid(out_valid), .UncondBr(UncondBr),
        .BrTaken(BrTaken), .CondAddr19(CondAddr19), .BrAddr26(BrAddr26), .flags(flags)
    );

    always #5 clk = ~clk;

    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, v;
        n = f[3]; z = f[2]; v = f[0];
        if (cc == 4'd0)  return z;
        if (cc == 4'd1)  return !z;
        if (cc == 4'd10) return n == v;
        if (cc == 4'd11) return n != v;
        if (cc == 4'd12) return !z && n == v;
        if (cc == 4'd13) return z || n != v;
        return 1'b0;
    endfunction

    task automatic step(input logic rst, input logic v, input logic st, input logic [31:0] ins,
                        input logic [63:0] rt, input logic fwe, input logic [3:0] fin);
        exp_t e;
        logic [3:0] f_use;
        logic signed [18:0] off19;
        logic signed [25:0] off26;
        logic br_taken;
        reset = rst; in_valid = v; stall = st; instr = ins; rt_data = rt; flag_we = fwe; flag_in = fin;
        e.chk_fields = 1'b1;
        if (rst) begin
            m_valid = 0; m_unc = 0; m_taken = 0; m_c19 = 0; m_b26 = 0; m_flags = 0; m_squash = 0;
        end else begin
            f_use = fwe ? fin : m_flags;
            if (!st) begin
                if (v && m_squash) begin
                    m_valid = 0; m_taken = 0; m_squash = 0;
                    e.chk_fields = 1'b0;
                end else if (v) begin
                    off19 = ins[23:5];
                    off26 = ins[25:0];
                    if (ins[31:26] == 6'b000101) br_taken = 1;
                    else if (ins[31:24] == 8'hB4) br_taken = (rt == 0);
                    else if (ins[31:24] == 8'h54) br_taken = cond_holds(ins[3:0], f_use);
                    else br_taken = 0;
                    m_valid = 1;
                    m_unc = (ins[31:26] == 6'b000101);
                    m_taken = br_taken;
                    m_c19 = 64'(off19);
                    m_b26 = 64'(off26);
                    m_squash = br_taken;
                end else begin
                    m_valid = 0; m_taken = 0;
                end
            end
            if (fwe) m_flags = fin;
        end
        e.valid = m_valid; e.unc = m_unc; e.taken = m_taken;
        e.c19 = m_c19; e.b26 = m_b26; e.flags = m_flags;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: one registered output set per clock, compared at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("in_ready", {63'd0, in_ready}, {63'd0, !stall});
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_valid", {63'd0, out_valid}, {63'd0, e.valid});
                chk("BrTaken", {63'd0, BrTaken}, {63'd0, e.taken});
                chk("flags", {60'd0, flags}, {60'd0, e.flags});
                if (e.chk_fields) begin
                    chk("UncondBr", {63'd0, UncondBr}, {63'd0, e.unc});
                    chk("CondAddr19", CondAddr19, e.c19);
                    chk("BrAddr26", BrAddr26, e.b26);
                end
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        int ccs[8] = '{0, 1, 10, 11, 12, 13, 5, 14};
        r = $urandom;
        k = $urandom_range(0, 3);
        if (k == 0) r[31:26] = 6'b000101;
        else if (k == 1) r[31:24] = 8'hB4;
        else if (k == 2) begin r[31:24] = 8'h54; r[3:0] = 4'(ccs[$urandom_range(0, 7)]); end
        return r;
    endfunction

    localparam logic [31:0] ADD = 32'h8B020020;
    localparam logic [31:0] SUB = 32'hCB020020;

    initial begin
        reset = 1; in_valid = 0; stall = 0; instr = 0; rt_data = 0; flag_we = 0; flag_in = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h17FFFFFF, 0, 1, 4'hF);
        step(0, 0, 0, 0, 0, 0, 0);
        // B with all-ones imm26, then a filler that is squashed
        step(0, 1, 0, 32'h17FFFFFF, 0, 0, 0);
        step(0, 1, 0, ADD, 0, 0, 0);
        // CBZ taken / not taken with imm19 = 0x10
        step(0, 1, 0, 32'hB4000201, 64'd0, 0, 0);
        step(0, 1, 0, ADD, 0, 0, 0);
        step(0, 1, 0, 32'hB4000201, 64'd5, 0, 0);
        // B.EQ with same-cycle flag write, then B.NE (dropped), then B.NE issued
        step(0, 1, 0, 32'h54000000, 0, 1, 4'b0100);
        step(0, 1, 0, 32'h54000001, 0, 0, 0);
        step(0, 1, 0, 32'h54000001, 0, 0, 0);
        // taken B, ADD squashed, SUB issued
        step(0, 1, 0, 32'h14000004, 0, 0, 0);
        step(0, 1, 0, ADD, 0, 0, 0);
        step(0, 1, 0, SUB, 0, 0, 0);
        // taken B, 3 stalled cycles with flag write, first instruction after stall squashed
        step(0, 1, 0, 32'h14000008, 0, 0, 0);
        step(0, 1, 1, ADD, 0, 1, 4'b1001);
        step(0, 1, 1, SUB, 0, 0, 0);
        step(0, 1, 1, ADD, 0, 0, 0);
        step(0, 1, 0, SUB, 0, 0, 0);
        step(0, 1, 0, ADD, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // reset during SQUASH with stall; next taken B must issue
        step(0, 1, 0, 32'h17000000, 0, 1, 4'b0110);
        step(1, 1, 1, ADD, 0, 1, 4'hF);
        step(0, 1, 0, 32'h14000001, 0, 0, 0);
        step(0, 1, 0, ADD, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 20,
                 rand_instr(), ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom},
                 $urandom_range(0, 99) < 30, 4'($urandom));
        end
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
